// File: rtl/input_pkg.sv
// Shared definitions for the button/switch input front end: debounce FSM
// state encoding and the default sizing parameters.
package input_pkg;

    localparam int DATA_W_DEF          = 18;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } deb_state_t;

    // The clean level is high while the press is accepted, including while a release is being confirmed.
    function automatic logic is_pressed(input deb_state_t s);
        return (s == PRESSIONADO) || (s == CONF_SOLTA);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; resets to all zeros.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two-stage synchronisation chain with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_meta <= {W{1'b0}};
            r_sync <= {W{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/input_debounce.sv
// Synchronises the KEY button and switches, debounces the button, and captures
// the switch word on a confirmed press while an input instruction is active.
module input_debounce
    import input_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_raw,
    input  logic [DATA_W-1:0] switch_raw,
    input  logic              escreveInput,
    output logic              btn_limpo,
    output logic              btn_pulso,
    output logic [DATA_W-1:0] switch_sync,
    output logic [DATA_W-1:0] dado,
    output logic              dado_valido
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              w_btn_s;
    logic [DATA_W-1:0] w_switch_sync;

    deb_state_t        r_state;
    deb_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_press;

    logic              r_limpo;
    logic              r_pulso;
    logic [DATA_W-1:0] r_dado;
    logic              r_valido;

    // KEY is active-low; invert before synchronising so btn_s is 1 when pressed.
    sync_2ff #(.W(1)) u_sync_btn (
        .clock (clock),
        .reset (reset),
        .i_d   (~btn_raw),
        .o_q   (w_btn_s)
    );

    sync_2ff #(.W(DATA_W)) u_sync_sw (
        .clock (clock),
        .reset (reset),
        .i_d   (switch_raw),
        .o_q   (w_switch_sync)
    );

    // Debounce next-state and saturating stability counter.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            SOLTO: begin
                if (w_btn_s) begin
                    w_state_next = CONF_PRESS;
                end else begin
                    w_state_next = SOLTO;
                end
            end
            CONF_PRESS: begin
                if (!w_btn_s) begin
                    w_state_next = SOLTO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = PRESSIONADO;
                end else begin
                    w_state_next = CONF_PRESS;
                end
            end
            PRESSIONADO: begin
                if (!w_btn_s) begin
                    w_state_next = CONF_SOLTA;
                end else begin
                    w_state_next = PRESSIONADO;
                end
            end
            CONF_SOLTA: begin
                if (w_btn_s) begin
                    w_state_next = PRESSIONADO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = SOLTO;
                end else begin
                    w_state_next = CONF_SOLTA;
                end
            end
            default: begin
                w_state_next = SOLTO;
            end
        endcase

        if (w_state_next != r_state) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (((r_state == CONF_PRESS) || (r_state == CONF_SOLTA)) && (r_cnt != CNT_MAX)) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    assign w_press = (r_state == CONF_PRESS) && (w_state_next == PRESSIONADO);

    // State, counter, registered outputs and switch capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= SOLTO;
            r_cnt    <= {CNT_W{1'b0}};
            r_limpo  <= 1'b0;
            r_pulso  <= 1'b0;
            r_dado   <= {DATA_W{1'b0}};
            r_valido <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_limpo  <= is_pressed(w_state_next);
            r_pulso  <= w_press;
            r_valido <= w_press && escreveInput;
            if (w_press && escreveInput) begin
                r_dado <= w_switch_sync;
            end else begin
                r_dado <= r_dado;
            end
        end
    end

    assign btn_limpo   = r_limpo;
    assign btn_pulso   = r_pulso;
    assign switch_sync = w_switch_sync;
    assign dado        = r_dado;
    assign dado_valido = r_valido;

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce with a short debounce window;
// captured words are checked against a scoreboard queue.
module tb_input_debounce;
    import input_pkg::*;

    localparam int DW  = 18;
    localparam int DEB = 4;
    localparam int CW  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          btn_raw;
    logic [DW-1:0] switch_raw;
    logic          escreveInput;
    logic          btn_limpo;
    logic          btn_pulso;
    logic [DW-1:0] switch_sync;
    logic [DW-1:0] dado;
    logic          dado_valido;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int valid_cnt = 0;
    logic prev_pulso = 1'b0;
    logic [DW-1:0] exp_q[$];

    input_debounce #(.DATA_W(DW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_raw      (btn_raw),
        .switch_raw   (switch_raw),
        .escreveInput (escreveInput),
        .btn_limpo    (btn_limpo),
        .btn_pulso    (btn_pulso),
        .switch_sync  (switch_sync),
        .dado         (dado),
        .dado_valido  (dado_valido)
    );

    always #5 clock = ~clock;

    // Output monitor: pulse accounting and scoreboard pop on each capture strobe.
    always @(negedge clock) begin
        if (btn_pulso) pulse_cnt++;
        if (btn_pulso && prev_pulso) begin
            checks++; errors++;
            $display("FAIL pulse_width: btn_pulso high two cycles in a row, required single cycle");
        end
        prev_pulso = btn_pulso;
        if (dado_valido) begin
            valid_cnt++;
            checks++;
            if (!btn_pulso) begin
                errors++;
                $display("FAIL valid_vs_pulse: dado_valido=1 btn_pulso=%0b, required btn_pulso=1", btn_pulso);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_capture: dado=%h captured, required no capture", dado);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                checks++;
                if (dado !== e) begin
                    errors++;
                    $display("FAIL capture_value: dado=%h, required %h", dado, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_release(input int hold);
        btn_raw = 1'b0;
        cyc(hold);
        btn_raw = 1'b1;
        cyc(12);
    endtask

    task automatic test_reset();
        int p0;
        reset = 1'b0; btn_raw = 1'b0; switch_raw = 18'h3FFFF; escreveInput = 1'b0;
        cyc(3);
        checks++;
        if ({btn_limpo, btn_pulso, dado_valido} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: limpo/pulso/valido=%b, required 000", {btn_limpo, btn_pulso, dado_valido});
        end
        checks++;
        if (switch_sync !== 18'h00000) begin
            errors++;
            $display("FAIL reset_switch_sync: %h, required 00000", switch_sync);
        end
        checks++;
        if (dado !== 18'h00000) begin
            errors++;
            $display("FAIL reset_dado: %h, required 00000", dado);
        end
        p0 = pulse_cnt;
        reset = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            checks++;
            if (btn_limpo !== (k == 7)) begin
                errors++;
                $display("FAIL latency_limpo: cycle %0d limpo=%b, required %b", k, btn_limpo, (k == 7));
            end
        end
        checks++;
        if (btn_pulso !== 1'b1) begin
            errors++;
            $display("FAIL latency_pulso: btn_pulso=%b, required 1", btn_pulso);
        end
        checks++;
        if (switch_sync !== 18'h3FFFF) begin
            errors++;
            $display("FAIL switch_pass: %h, required 3ffff", switch_sync);
        end
        btn_raw = 1'b1;
        cyc(12);
        checks++;
        if (btn_limpo !== 1'b0) begin
            errors++;
            $display("FAIL release_limpo: %b, required 0", btn_limpo);
        end
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            errors++;
            $display("FAIL reset_pulses: %0d, required 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_clean_press();
        int p0, v0;
        escreveInput = 1'b1; switch_raw = 18'h0002A;
        cyc(3);
        p0 = pulse_cnt; v0 = valid_cnt;
        exp_q.push_back(18'h0002A);
        btn_raw = 1'b0;
        cyc(20);
        checks++;
        if (btn_limpo !== 1'b1) begin
            errors++;
            $display("FAIL hold_limpo: %b, required 1", btn_limpo);
        end
        btn_raw = 1'b1;
        cyc(12);
        checks++;
        if (pulse_cnt - p0 !== 1 || valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL clean_counts: pulses=%0d valids=%0d, required 1 and 1", pulse_cnt - p0, valid_cnt - v0);
        end
        checks++;
        if (dado !== 18'h0002A || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clean_dado: dado=%h pending=%0d, required 0002a and 0", dado, exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int p0;
        logic seen;
        p0 = pulse_cnt; seen = 1'b0;
        btn_raw = 1'b0; cyc(2);
        btn_raw = 1'b1; cyc(1);
        btn_raw = 1'b0; cyc(2);
        btn_raw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (btn_limpo) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || pulse_cnt != p0) begin
            errors++;
            $display("FAIL bounce: limpo_seen=%b pulses=%0d, required 0 and 0", seen, pulse_cnt - p0);
        end
        checks++;
        if (dut.r_state !== SOLTO) begin
            errors++;
            $display("FAIL bounce_state: %0d, required SOLTO", dut.r_state);
        end
    endtask

    task automatic test_no_write();
        int p0, v0;
        escreveInput = 1'b0; switch_raw = 18'h00055;
        cyc(3);
        p0 = pulse_cnt; v0 = valid_cnt;
        press_release(12);
        checks++;
        if (pulse_cnt - p0 !== 1 || valid_cnt != v0) begin
            errors++;
            $display("FAIL nowrite_counts: pulses=%0d valids=%0d, required 1 and 0", pulse_cnt - p0, valid_cnt - v0);
        end
        checks++;
        if (dado !== 18'h0002A) begin
            errors++;
            $display("FAIL nowrite_dado: %h, required 0002a", dado);
        end
    endtask

    task automatic test_held_then_write();
        int p0, v0;
        escreveInput = 1'b0;
        p0 = pulse_cnt; v0 = valid_cnt;
        btn_raw = 1'b0;
        cyc(12);
        escreveInput = 1'b1;
        cyc(10);
        checks++;
        if (pulse_cnt - p0 !== 1 || valid_cnt != v0) begin
            errors++;
            $display("FAIL held_counts: pulses=%0d valids=%0d, required 1 and 0", pulse_cnt - p0, valid_cnt - v0);
        end
        switch_raw = 18'h00077;
        cyc(3);
        btn_raw = 1'b1;
        cyc(12);
        exp_q.push_back(18'h00077);
        press_release(12);
        checks++;
        if (valid_cnt - v0 !== 1 || dado !== 18'h00077) begin
            errors++;
            $display("FAIL repress_capture: valids=%0d dado=%h, required 1 and 00077", valid_cnt - v0, dado);
        end
    endtask

    task automatic test_reset_mid_count();
        int p0, v0;
        p0 = pulse_cnt; v0 = valid_cnt;
        btn_raw = 1'b0;
        cyc(5);
        checks++;
        if (dut.r_state !== CONF_PRESS || dut.r_cnt !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset: state=%0d cnt=%0d, required CONF_PRESS and 2", dut.r_state, dut.r_cnt);
        end
        reset = 1'b0; btn_raw = 1'b1;
        cyc(1);
        checks++;
        if (dut.r_state !== SOLTO || dut.r_cnt !== 3'd0 || dado !== 18'h00000) begin
            errors++;
            $display("FAIL mid_reset: state=%0d cnt=%0d dado=%h, required SOLTO 0 00000", dut.r_state, dut.r_cnt, dado);
        end
        reset = 1'b1;
        cyc(15);
        checks++;
        if (pulse_cnt != p0 || valid_cnt != v0 || btn_limpo !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: pulses=%0d valids=%0d limpo=%b, required 0 0 0", pulse_cnt - p0, valid_cnt - v0, btn_limpo);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_no_write();
        test_held_then_write();
        test_reset_mid_count();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected captures never seen", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
